// File: rtl/dfswt_pkg.sv
// rtl/dfswt_pkg.sv - shared types and helpers for the dfswt peak tracker
package dfswt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DECIDE
  } state_t;

  localparam int DEFAULT_MAG_W = 32;

  // Low bit of bin idx within a flattened bus of mag_w-wide magnitudes.
  function automatic int bin_lsb(input int idx, input int mag_w);
    return idx * mag_w;
  endfunction

endpackage

// File: rtl/dfswt_hysteresis.sv
// rtl/dfswt_hysteresis.sv - commits a bin/tone result only after HOLD consistent frames
module dfswt_hysteresis
  import dfswt_pkg::*;
#(
  parameter int BIN_W = 2,
  parameter int HOLD  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             decide,
  input  logic [BIN_W-1:0] cand_bin,
  input  logic             cand_tone,
  output logic [BIN_W-1:0] bin,
  output logic             tone
);

  localparam int CNT_W = $clog2(HOLD + 1);

  logic [BIN_W-1:0] pend_bin;
  logic             pend_tone;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             match;

  // A no-tone candidate matches any pending no-tone, whatever its bin.
  always_comb begin
    match    = cand_tone ? (pend_tone && (pend_bin == cand_bin)) : !pend_tone;
    next_cnt = CNT_W'(1);
    if (match) begin
      next_cnt = (hold_cnt == CNT_W'(HOLD)) ? hold_cnt : hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_bin  <= '0;
      pend_tone <= 1'b0;
      hold_cnt  <= '0;
      bin       <= '0;
      tone      <= 1'b0;
    end else if (!enable) begin
      pend_bin  <= '0;
      pend_tone <= 1'b0;
      hold_cnt  <= '0;
    end else if (decide) begin
      if (!match) begin
        pend_bin  <= cand_bin;
        pend_tone <= cand_tone;
      end
      hold_cnt <= next_cnt;
      if (next_cnt == CNT_W'(HOLD)) begin
        tone <= cand_tone;
        if (cand_tone) begin
          bin <= cand_bin;
        end
      end
    end
  end

endmodule

// File: rtl/dfswt_peak_tracker.sv
// rtl/dfswt_peak_tracker.sv - sequential peak-bin search with threshold and hysteresis
module dfswt_peak_tracker
  import dfswt_pkg::*;
#(
  parameter int BINS  = 4,
  parameter int MAG_W = DEFAULT_MAG_W,
  parameter int HOLD  = 3,
  parameter int BIN_W = $clog2(BINS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mag_valid,
  input  logic [BINS*MAG_W-1:0] mag_bus,
  input  logic [MAG_W-1:0]      threshold,
  output logic                  busy,
  output logic                  out_valid,
  output logic [BIN_W-1:0]      bin,
  output logic                  tone,
  output logic                  overrun
);

  state_t                  state;
  logic [BINS*MAG_W-1:0]   frame_buf;
  logic signed [MAG_W-1:0] thr_q;
  logic signed [MAG_W-1:0] run_max;
  logic signed [MAG_W-1:0] cur_mag;
  logic [BIN_W-1:0]        idx;
  logic [BIN_W-1:0]        run_bin;
  logic                    decide;
  logic                    cand_tone;

  assign cur_mag   = frame_buf[bin_lsb(int'(idx), MAG_W) +: MAG_W];
  assign decide    = enable && (state == DECIDE);
  assign cand_tone = (run_max > 0) && (run_max >= thr_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      frame_buf <= '0;
      thr_q     <= '0;
      run_max   <= '0;
      run_bin   <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // DECIDE still counts as busy, so a strobe there is dropped too.
      if (enable && mag_valid && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      if (!enable) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (mag_valid) begin
              frame_buf <= mag_bus;
              thr_q     <= threshold;
              idx       <= '0;
              run_max   <= '0;
              run_bin   <= '0;
              busy      <= 1'b1;
              state     <= SCAN;
            end
          end
          SCAN: begin
            if (cur_mag > run_max) begin
              run_max <= cur_mag;
              run_bin <= idx;
            end
            if (idx == BIN_W'(BINS - 1)) begin
              state <= DECIDE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          DECIDE: begin
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  dfswt_hysteresis #(
    .BIN_W (BIN_W),
    .HOLD  (HOLD)
  ) u_hyst (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .decide    (decide),
    .cand_bin  (run_bin),
    .cand_tone (cand_tone),
    .bin       (bin),
    .tone      (tone)
  );

endmodule
